// File: rtl/bt_mskreg_sched.sv
// bt_mskreg_sched
// Round scheduler for a masked state register with enable and Borrowed-Time
// (BT) clear. For every round it fetches fresh randomness, holds the BT clear
// for CLR_CYC cycles, and then issues one enable (update) cycle.
//
// Parameters:
//   COUNT   - number of masked variables; width of the randomness bus
//   ROUNDS  - round updates per operation (1..255)
//   CLR_CYC - cycles reg_clear is held per round (1..15)
//   RW      - width of the round index (2^RW > ROUNDS-1)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request to begin an operation, sampled only in IDLE
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse after the final round is written
//   rnd_in    in   fresh randomness
//   rnd_valid in   rnd_in is valid
//   rnd_ready out  scheduler accepts rnd_in this cycle
//   load      out  datapath selects initial shares instead of round output
//   reg_en    out  enable to the masked register
//   reg_rnd   out  BT randomness to the masked register
//   reg_clear out  BT clear to the masked register
//   round     out  index of the round being processed
//   last      out  round == ROUNDS-1 while an operation is active

module bt_mskreg_sched #(
  parameter int COUNT   = 64,
  parameter int ROUNDS  = 40,
  parameter int CLR_CYC = 1,
  parameter int RW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [COUNT-1:0] rnd_in,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic             load,
  output logic             reg_en,
  output logic [COUNT-1:0] reg_rnd,
  output logic             reg_clear,
  output logic [RW-1:0]    round,
  output logic             last
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [3:0]    CLR_LAST   = 4'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REFRESH,
    S_CLEAR,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [3:0]       clr_cnt;
  logic [3:0]       clr_cnt_d;
  logic [RW-1:0]    round_d;
  logic [COUNT-1:0] reg_rnd_d;
  logic             hs;

  // rnd_ready is only ever high in REFRESH, so the state term just makes the
  // capture condition explicit.
  assign hs = (state == S_REFRESH) && rnd_valid && rnd_ready;

  // State and clear-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
    end
  end

  // Next-state logic, plus the next values of the round index and the captured
  // randomness. The counter returns to 0 whenever CLEAR is left or not active.
  always_comb begin
    state_d   = state;
    clr_cnt_d = '0;
    round_d   = round;
    reg_rnd_d = reg_rnd;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          round_d = '0;
        end
      end
      S_LOAD: begin
        state_d = S_REFRESH;
      end
      S_REFRESH: begin
        if (hs) begin
          state_d   = S_CLEAR;
          reg_rnd_d = rnd_in;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_d = S_UPDATE;
        end else begin
          clr_cnt_d = clr_cnt + 4'd1;
        end
      end
      S_UPDATE: begin
        // last already reflects round == ROUNDS-1, so the index saturates there.
        if (last) begin
          state_d   = S_DONE;
          reg_rnd_d = '0;
        end else begin
          state_d = S_REFRESH;
          round_d = round + RW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each one is valid during the
  // very cycle its state is active, without any decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rnd_ready <= 1'b0;
      load      <= 1'b0;
      reg_en    <= 1'b0;
      reg_clear <= 1'b0;
      last      <= 1'b0;
      round     <= '0;
      reg_rnd   <= '0;
    end else begin
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      rnd_ready <= (state_d == S_REFRESH);
      load      <= (state_d == S_LOAD);
      reg_en    <= (state_d == S_LOAD) || (state_d == S_UPDATE);
      reg_clear <= (state_d == S_CLEAR);
      last      <= (state_d != S_IDLE) && (round_d == LAST_ROUND);
      round     <= round_d;
      reg_rnd   <= reg_rnd_d;
    end
  end

endmodule

// File: doc/bt_mskreg_sched.md
Name: bt_mskreg_sched

Overview:
- Round scheduler for a masked state register with enable and Borrowed-Time (BT) clear.
- Sequences, per round: fetch fresh randomness, drive a BT clear phase, then issue one enable (update) cycle.
- Sits between the core top-level start/done handshake, the TRNG/PRNG randomness source (valid/ready), and the en/rnd/clear pins of the masked state registers in the round-based SKINNY core.

Parameters:
- COUNT, 64, number of masked variables in the controlled register; width of the randomness bus.
- ROUNDS, 40, number of round updates per operation; legal range 1..255.
- CLR_CYC, 1, cycles reg_clear is held high per round; legal range 1..15.
- RW, 8, width of the round output; must satisfy 2^RW > ROUNDS-1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled request to begin an operation; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final round has been written.
- rnd_in  in  COUNT  fresh randomness.
- rnd_valid  in  1  rnd_in is valid.
- rnd_ready  out  1  scheduler accepts rnd_in this cycle.
- load  out  1  datapath mux selects the initial (plaintext/key) shares instead of round output.
- reg_en  out  1  enable to the masked register.
- reg_rnd  out  COUNT  BT randomness to the masked register.
- reg_clear  out  1  BT clear to the masked register.
- round  out  RW  index of the round currently being processed.
- last  out  1  round == ROUNDS-1.

Behaviour:
- Output timing:
  - All outputs are driven directly from flops; no combinational decode from inputs to outputs.
  - Exception: rnd_ready is a flop, but the handshake condition is rnd_valid & rnd_ready.
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, rnd_ready, load, reg_en, reg_clear, last = 0.
  - reg_rnd = 0; round = 0; clear-cycle counter = 0.
- FSM states: IDLE, LOAD, REFRESH, CLEAR, UPDATE, DONE.
- IDLE:
  - All control outputs 0; reg_rnd holds 0.
  - start=1 -> LOAD next cycle.
- LOAD (1 cycle):
  - load=1, reg_en=1, round=0.
  - -> REFRESH.
- REFRESH:
  - rnd_ready=1; reg_en=0, reg_clear=0.
  - On rnd_valid&rnd_ready: reg_rnd <= rnd_in, rnd_ready drops, -> CLEAR.
  - Stalls indefinitely while rnd_valid=0; nothing else changes during the stall.
- CLEAR (exactly CLR_CYC cycles):
  - reg_clear=1; reg_rnd held stable; counter counts from 0 to CLR_CYC-1.
  - -> UPDATE.
- UPDATE (1 cycle):
  - reg_en=1, reg_clear=0.
  - If last=1 -> DONE. Otherwise round increments, last is recomputed, -> REFRESH.
- DONE (1 cycle):
  - done=1, busy=1, reg_rnd <= 0.
  - -> IDLE. round holds ROUNDS-1 until the next LOAD.
- Invariants:
  - reg_en and reg_clear are never high in the same cycle.
  - reg_rnd never changes while reg_clear=1 or reg_en=1.
  - Randomness is consumed exactly once per round: exactly ROUNDS handshakes per operation.
- Latency, with rnd_valid held at 1:
  - The start-sampling edge enters LOAD.
  - Each round takes 2+CLR_CYC cycles.
  - done asserts 1+ROUNDS*(2+CLR_CYC) cycles after LOAD is entered.
  - busy is high for 2+ROUNDS*(2+CLR_CYC) cycles.
- Boundary and simultaneous-event rules:
  - start while busy: ignored. start held high through DONE: a new operation begins on the cycle after DONE (IDLE sees start).
  - ROUNDS=1: LOAD, REFRESH, CLEAR, UPDATE, DONE; last=1 from LOAD onward.
  - round wraps never; the counter saturates at ROUNDS-1.
  - rnd_valid asserted outside REFRESH: ignored, no capture.
  - rst_n low mid-operation: immediate return to IDLE, all outputs to reset values; a partially processed register is not flagged (the top level discards it).

Test Plan:
- COUNT=8, ROUNDS=4, CLR_CYC=2, rnd_valid=1 constantly, rnd_in=round-dependent (0xA0+round), 1-cycle start pulse -> LOAD 1 cycle with load=reg_en=1; per round reg_clear high 2 cycles then reg_en 1 cycle; reg_rnd=0xA0,0xA1,0xA2,0xA3 during the clear of rounds 0..3; done 17 cycles after LOAD; busy 18 cycles.
- Same config, rnd_valid low for 5 cycles in round 2's REFRESH -> rnd_ready stays 1, reg_en=reg_clear=0 for those cycles, round stays 2, total latency +5, exactly 4 handshakes.
- rnd_valid pulsed during CLEAR and UPDATE with rnd_in=0xFF -> reg_rnd unchanged, no handshake counted.
- start re-pulsed during round 1 and held high across DONE -> mid-op start ignored; second operation's LOAD occurs 2 cycles after done pulse (IDLE then LOAD), round resets to 0.
- rst_n asserted in CLEAR of round 2 -> same-cycle (async) busy=0, reg_clear=0, reg_rnd=0, round=0; after release, IDLE until start.
- ROUNDS=1, CLR_CYC=1 -> sequence LOAD, REFRESH, CLEAR, UPDATE, DONE = 5 cycles busy; last=1 throughout; reg_en and reg_clear never overlap (assertion checked every cycle).
